// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer: FSM states,
// active-low 7-segment patterns (bit6..bit0 = g..a) and a BCD 00..59 increment.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Two-digit BCD increment that wraps 59 -> 00 with no carry out.
  function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/seg7_bcd.sv
// Combinational BCD digit to active-low 7-segment decoder; non-BCD codes blank.
module seg7_bcd
  import countdown_timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with debounced push-buttons, BCD digits held as
// {min tens, min ones, sec tens, sec ones}, and a 2 Hz blinking expiry display.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] key,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       alarm,
  output logic       running
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [PW-1:0] TICK_LAST  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] BLINK_LAST = PW'(CLK_HZ / 4 - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);

  logic [2:0] press;

  for (genvar i = 0; i < 3; i++) begin : g_key
    logic          sync1, sync2, level, level_d, pulse;
    logic [DW-1:0] cnt;

    always_ff @(posedge clock) begin
      if (reset) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        level   <= 1'b1;
        level_d <= 1'b1;
        cnt     <= '0;
        pulse   <= 1'b0;
      end else begin
        sync1 <= key[i];
        sync2 <= sync1;
        if (sync2 == level)
          cnt <= '0;
        else if (cnt == DB_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else
          cnt <= cnt + 1'b1;
        level_d <= level;
        pulse   <= level_d & ~level;
      end
    end

    assign press[i] = pulse;
  end

  logic start, inc_min, inc_sec;
  assign start   = press[0];
  assign inc_min = press[1] & ~press[0];
  assign inc_sec = press[2] & ~press[1] & ~press[0];

  state_t        state;
  logic [15:0]   digits;
  logic [15:0]   preset;
  logic [15:0]   dec;
  logic [PW-1:0] presc;
  logic [PW-1:0] bcnt;
  logic          phase;

  // One-second BCD decrement with borrow through seconds into minutes.
  always_comb begin
    dec = digits;
    if (digits[3:0] != 4'd0)
      dec[3:0] = digits[3:0] - 4'd1;
    else begin
      dec[3:0] = 4'd9;
      if (digits[7:4] != 4'd0)
        dec[7:4] = digits[7:4] - 4'd1;
      else begin
        dec[7:4] = 4'd5;
        if (digits[11:8] != 4'd0)
          dec[11:8] = digits[11:8] - 4'd1;
        else begin
          dec[11:8]  = 4'd9;
          dec[15:12] = digits[15:12] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      digits  <= '0;
      preset  <= '0;
      presc   <= '0;
      bcnt    <= '0;
      phase   <= 1'b0;
      alarm   <= 1'b0;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (digits != '0) begin
              state   <= RUN;
              running <= 1'b1;
              presc   <= '0;
            end
          end else if (inc_min) begin
            digits[15:8] <= bcd_inc59(digits[15:8]);
            preset       <= {bcd_inc59(digits[15:8]), digits[7:0]};
          end else if (inc_sec) begin
            digits[7:0] <= bcd_inc59(digits[7:0]);
            preset      <= {digits[15:8], bcd_inc59(digits[7:0])};
          end
        end
        RUN: begin
          // A pause press freezes the prescaler on this edge too, so a
          // coincident tick is not applied.
          if (start) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (presc == TICK_LAST) begin
            presc  <= '0;
            digits <= dec;
            if (dec == '0) begin
              state   <= EXPIRED;
              running <= 1'b0;
              alarm   <= 1'b1;
              bcnt    <= '0;
              phase   <= 1'b0;
            end
          end else
            presc <= presc + 1'b1;
        end
        PAUSE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        EXPIRED: begin
          if (|press) begin
            state  <= IDLE;
            alarm  <= 1'b0;
            digits <= preset;
            phase  <= 1'b0;
          end else if (bcnt == BLINK_LAST) begin
            bcnt  <= '0;
            phase <= ~phase;
          end else
            bcnt <= bcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [6:0] seg_s0, seg_s1, seg_m0, seg_m1;
  logic       blank;

  seg7_bcd u_seg_s0 (.bcd(digits[3:0]),   .seg(seg_s0));
  seg7_bcd u_seg_s1 (.bcd(digits[7:4]),   .seg(seg_s1));
  seg7_bcd u_seg_m0 (.bcd(digits[11:8]),  .seg(seg_m0));
  seg7_bcd u_seg_m1 (.bcd(digits[15:12]), .seg(seg_m1));

  assign blank = (state == EXPIRED) && phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      hex0 <= SEG_0;
      hex1 <= SEG_0;
      hex2 <= SEG_0;
      hex3 <= SEG_0;
    end else begin
      hex0 <= blank ? SEG_BLANK : seg_s0;
      hex1 <= blank ? SEG_BLANK : seg_s1;
      hex2 <= blank ? SEG_BLANK : seg_m0;
      hex3 <= blank ? SEG_BLANK : seg_m1;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized self-checking bench for countdown_timer against a seconds/minutes
// arithmetic model, plus directed anchors with fixed expected displays.
module tb_countdown_timer;

  localparam int CLK_HZ  = 8;
  localparam int DEB     = 2;
  localparam int SCHED_N = 40000;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] key;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       alarm, running;

  countdown_timer #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB)) dut (
    .clock(clock), .reset(reset), .key(key),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .alarm(alarm), .running(running)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode, mm, ss, pm, ps, presc, expc;
  logic [2:0] sched [SCHED_N];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] show(input int m, input int s);
    return {seg_of(m / 10), seg_of(m % 10), seg_of(s / 10), seg_of(s % 10)};
  endfunction

  function automatic logic [27:0] disp();
    if (mode == M_EXP && ((expc / (CLK_HZ / 4)) % 2) == 1) return {4{7'h7F}};
    return show(mm, ss);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic model_edge(input logic r, input logic [2:0] p);
    int t;
    if (r) begin
      mode = M_IDLE; mm = 0; ss = 0; pm = 0; ps = 0; presc = 0; expc = 0;
      for (int i = cyc + 1; i < SCHED_N; i++) sched[i] = '0;
      return;
    end
    case (mode)
      M_IDLE: begin
        if (p[0]) begin
          if (mm * 60 + ss != 0) begin mode = M_RUN; presc = 0; end
        end else if (p[1]) begin
          mm = (mm + 1) % 60; pm = mm; ps = ss;
        end else if (p[2]) begin
          ss = (ss + 1) % 60; pm = mm; ps = ss;
        end
      end
      M_RUN: begin
        if (p[0]) mode = M_PAUSE;
        else if (presc == CLK_HZ - 1) begin
          presc = 0;
          t = mm * 60 + ss - 1;
          mm = t / 60; ss = t % 60;
          if (t == 0) begin mode = M_EXP; expc = 0; end
        end else presc++;
      end
      M_PAUSE: if (p[0]) mode = M_RUN;
      default: begin
        if (p != 3'b000) begin mode = M_IDLE; mm = pm; ss = ps; end
        else expc++;
      end
    endcase
  endtask

  task automatic step();
    logic [27:0] want_hex;
    logic [2:0]  p;
    logic        r;
    r = reset;
    want_hex = r ? {4{7'b1000000}} : disp();
    p = (cyc + 1 < SCHED_N) ? sched[cyc + 1] : 3'b000;
    @(posedge clock);
    cyc++;
    model_edge(r, p);
    #1;
    check("hex", {hex3, hex2, hex1, hex0}, want_hex);
    check("alarm", alarm, mode == M_EXP);
    check("running", running, mode == M_RUN);
  endtask

  // Key sampled low on the next edge takes effect DEB+3 edges after that.
  task automatic press(input logic [2:0] mask, input int hold, input int gap);
    if (hold >= DEB && cyc + DEB + 4 < SCHED_N)
      sched[cyc + DEB + 4] = sched[cyc + DEB + 4] | mask;
    key = ~mask;
    repeat (hold) step();
    key = '1;
    repeat (gap) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit aligned;
    key = '1;
    reset = 1'b1;
    mode = M_IDLE; mm = 0; ss = 0; pm = 0; ps = 0; presc = 0; expc = 0;
    for (int i = 0; i < SCHED_N; i++) sched[i] = '0;

    step();
    step();
    reset = 1'b0;
    check("rst_hex", {hex3, hex2, hex1, hex0}, {4{7'b1000000}});
    repeat (2) step();

    // Preset entry: three seconds, one minute.
    repeat (3) press(3'b100, DEB + 1, 6);
    press(3'b010, DEB + 1, 6);
    check("set_0103", {hex3, hex2, hex1, hex0}, show(1, 3));
    check("set_alarm", alarm, 1'b0);
    check("set_running", running, 1'b0);

    // Borrow across the minute boundary.
    do_reset();
    press(3'b010, DEB + 1, 6);
    press(3'b001, DEB + 1, 6);
    check("borrow_run", running, 1'b1);
    repeat (7) step();
    check("borrow_0059", {hex3, hex2, hex1, hex0}, show(0, 59));

    // Expiry, blink and reload from preset.
    do_reset();
    repeat (2) press(3'b100, DEB + 1, 6);
    press(3'b001, DEB + 1, 6);
    repeat (14) step();
    check("exp_alarm", alarm, 1'b1);
    check("exp_shown", {hex3, hex2, hex1, hex0}, show(0, 0));
    repeat (2) step();
    check("exp_blank", {hex3, hex2, hex1, hex0}, {4{7'h7F}});
    repeat (6) step();
    press(3'b010, DEB + 1, 6);
    check("reload_0002", {hex3, hex2, hex1, hex0}, show(0, 2));
    check("reload_alarm", alarm, 1'b0);

    // Pause pressed on a tick edge drops that tick.
    do_reset();
    repeat (3) press(3'b100, DEB + 1, 6);
    press(3'b001, DEB + 1, 6);
    aligned = 1'b0;
    for (int n = 0; n < 2 * CLK_HZ && !aligned; n++) begin
      if ((presc + DEB + 3) % CLK_HZ == CLK_HZ - 1) aligned = 1'b1;
      else step();
    end
    check("pause_align", {31'd0, aligned}, 32'd1);
    press(3'b001, DEB + 1, 6);
    check("pause_running", running, 1'b0);
    check("pause_0002", {hex3, hex2, hex1, hex0}, show(0, 2));
    repeat (20) step();
    check("pause_hold", {hex3, hex2, hex1, hex0}, show(0, 2));
    press(3'b010, DEB + 1, 6);
    press(3'b001, DEB + 1, 6);
    check("resume_running", running, 1'b1);
    repeat (20) step();
    check("resume_expired", alarm, 1'b1);

    // Reset in EXPIRED wins.
    do_reset();
    check("rst_exp_hex", {hex3, hex2, hex1, hex0}, show(0, 0));
    check("rst_exp_alarm", alarm, 1'b0);
    repeat (4) step();

    // Same-cycle start+minute: start wins; short glitch ignored.
    repeat (5) press(3'b100, DEB + 1, 6);
    press(3'b011, DEB + 1, 6);
    check("prio_running", running, 1'b1);
    check("prio_0005", {hex3, hex2, hex1, hex0}, show(0, 5));
    press(3'b001, 1, 8);
    check("glitch_running", running, 1'b1);

    // Randomized key traffic against the model.
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int k = 0; k < 10; k++) begin
        logic [2:0] m;
        int hold;
        m = 3'($urandom_range(1, 7));
        hold = ($urandom_range(0, 3) == 0) ? 1 : DEB + 1 + int'($urandom_range(0, 2));
        press(m, hold, int'($urandom_range(6, 40)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
